// File: rtl/game_pkg.sv
// Game-wide map definitions shared by the player control and drawing blocks.
//   tile       : per-cell content of the tile map
//   MAP_WIDTH  : map width in tiles
//   MAP_HEIGHT : map height in tiles
package game_pkg;
  localparam int MAP_WIDTH  = 32;
  localparam int MAP_HEIGHT = 24;

  // Encoding 2'd3 is unused; the drawer flags it with a debug colour.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PLAYER1 = 2'd1,
    PLAYER2 = 2'd2
  } tile;
endpackage

// File: rtl/vga_pkg.sv
// VGA colour constants (4:4:4 RGB) used by the drawing blocks.
package vga_pkg;
  localparam logic [11:0] PLAYER1_COLOR = 12'hF00;
  localparam logic [11:0] PLAYER2_COLOR = 12'h00F;
  localparam logic [11:0] GRID_COLOR    = 12'h333;
  localparam logic [11:0] DEBUG_COLOR   = 12'hF0F;
endpackage

// File: rtl/map_draw_snapshot.sv
// Once-per-frame map capture and blink state for map_draw.
//   clk, rst_n            : pixel clock, async active-low reset
//   i_map                 : live tile map
//   i_player1_collision   : live player-1 collision flag
//   i_vblnk               : vertical blank; its rising edge is the capture point
//   o_snap                : map as captured at the last vblnk rising edge
//   o_coll                : collision flag captured with the map
//   o_blink               : blink phase for collided PLAYER1 tiles
module map_draw_snapshot
  import game_pkg::*;
#(
  parameter int BLINK_FRAMES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  tile  i_map [MAP_WIDTH][MAP_HEIGHT],
  input  logic i_player1_collision,
  input  logic i_vblnk,
  output tile  o_snap [MAP_WIDTH][MAP_HEIGHT],
  output logic o_coll,
  output logic o_blink
);
  localparam logic [7:0] FRAME_LAST = 8'(BLINK_FRAMES - 1);

  tile        r_snap [MAP_WIDTH][MAP_HEIGHT];
  logic       r_vblnk_d;
  logic       r_armed;
  logic       r_coll;
  logic       r_blink;
  logic [7:0] r_frame;
  logic       w_edge;

  // r_armed suppresses the false edge seen when vblnk is already high as
  // reset releases (r_vblnk_d comes out of reset at 0).
  assign w_edge = i_vblnk & ~r_vblnk_d & r_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int x = 0; x < MAP_WIDTH; x++)
        for (int y = 0; y < MAP_HEIGHT; y++)
          r_snap[x][y] <= EMPTY;
      r_vblnk_d <= 1'b0;
      r_armed   <= 1'b0;
      r_coll    <= 1'b0;
      r_blink   <= 1'b0;
      r_frame   <= 8'd0;
    end else begin
      r_vblnk_d <= i_vblnk;
      r_armed   <= 1'b1;
      if (w_edge) begin
        r_snap <= i_map;
        r_coll <= i_player1_collision;
        if (r_frame == FRAME_LAST) begin
          r_frame <= 8'd0;
          r_blink <= i_player1_collision ? ~r_blink : 1'b0;
        end else begin
          r_frame <= r_frame + 8'd1;
          if (!i_player1_collision) r_blink <= 1'b0;
        end
      end
    end
  end

  assign o_snap  = r_snap;
  assign o_coll  = r_coll;
  assign o_blink = r_blink;
endmodule

// File: rtl/map_draw.sv
// Tile map overlay for the VGA chain: draws one coloured square per map tile
// over the background stream, from a per-frame snapshot of the map.
//   clk, rst_n           : pixel clock, async active-low reset
//   i_map                : live tile map
//   i_player1_collision  : player-1 collision flag (blinks PLAYER1 tiles)
//   i_hcount/i_vcount    : pixel counters (11 bit)
//   i_hsync/i_vsync      : sync strobes
//   i_hblnk/i_vblnk      : blanking strobes
//   i_rgb                : background pixel, 4:4:4
//   o_*                  : same signals delayed 2 cycles; o_rgb is composited
module map_draw
  import game_pkg::*;
  import vga_pkg::*;
#(
  parameter int TILE_SIZE    = 16,
  parameter int X_OFFSET     = 0,
  parameter int Y_OFFSET     = 0,
  parameter int BLINK_FRAMES = 16,
  parameter int GRID_EN      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  tile         i_map [MAP_WIDTH][MAP_HEIGHT],
  input  logic        i_player1_collision,
  input  logic [10:0] i_hcount,
  input  logic [10:0] i_vcount,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_hblnk,
  input  logic        i_vblnk,
  input  logic [11:0] i_rgb,
  output logic [10:0] o_hcount,
  output logic [10:0] o_vcount,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_hblnk,
  output logic        o_vblnk,
  output logic [11:0] o_rgb
);
  localparam int          SH       = $clog2(TILE_SIZE);
  localparam int          TXW      = $clog2(MAP_WIDTH);
  localparam int          TYW      = $clog2(MAP_HEIGHT);
  localparam logic [10:0] MAP_W_PX = 11'(MAP_WIDTH * TILE_SIZE);
  localparam logic [10:0] MAP_H_PX = 11'(MAP_HEIGHT * TILE_SIZE);

  tile  w_snap [MAP_WIDTH][MAP_HEIGHT];
  logic w_coll;
  logic w_blink;

  map_draw_snapshot #(.BLINK_FRAMES(BLINK_FRAMES)) u_snap (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_map               (i_map),
    .i_player1_collision (i_player1_collision),
    .i_vblnk             (i_vblnk),
    .o_snap              (w_snap),
    .o_coll              (w_coll),
    .o_blink             (w_blink)
  );

  // Offset subtraction one bit wider: bit 11 is the borrow, i.e. the pixel
  // lies left of / above the map area and must not wrap into it.
  logic [11:0] w_dx, w_dy;
  logic        w_in_map, w_on_grid;
  assign w_dx      = {1'b0, i_hcount} - 12'(X_OFFSET);
  assign w_dy      = {1'b0, i_vcount} - 12'(Y_OFFSET);
  assign w_in_map  = !w_dx[11] && (w_dx[10:0] < MAP_W_PX) &&
                     !w_dy[11] && (w_dy[10:0] < MAP_H_PX);
  assign w_on_grid = (GRID_EN != 0) &&
                     ((w_dx[SH-1:0] == '0) || (w_dy[SH-1:0] == '0));

  // Stage 1
  logic [10:0]    r1_hcount, r1_vcount;
  logic           r1_hsync, r1_vsync, r1_hblnk, r1_vblnk;
  logic [11:0]    r1_rgb;
  logic           r1_in_map, r1_on_grid;
  logic [TXW-1:0] r1_tx;
  logic [TYW-1:0] r1_ty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_hcount  <= '0;
      r1_vcount  <= '0;
      r1_hsync   <= 1'b0;
      r1_vsync   <= 1'b0;
      r1_hblnk   <= 1'b0;
      r1_vblnk   <= 1'b0;
      r1_rgb     <= '0;
      r1_in_map  <= 1'b0;
      r1_on_grid <= 1'b0;
      r1_tx      <= '0;
      r1_ty      <= '0;
    end else begin
      r1_hcount  <= i_hcount;
      r1_vcount  <= i_vcount;
      r1_hsync   <= i_hsync;
      r1_vsync   <= i_vsync;
      r1_hblnk   <= i_hblnk;
      r1_vblnk   <= i_vblnk;
      r1_rgb     <= i_rgb;
      r1_in_map  <= w_in_map;
      r1_on_grid <= w_on_grid;
      // Upper bits are zero whenever in_map holds, so the slice is exact.
      r1_tx      <= w_dx[SH +: TXW];
      r1_ty      <= w_dy[SH +: TYW];
    end
  end

  // Stage 2 colour select
  tile         w_tile;
  logic [11:0] w_rgb;

  always_comb begin
    w_tile = EMPTY;
    if (r1_in_map) w_tile = w_snap[r1_tx][r1_ty];
    w_rgb = r1_rgb;
    if (r1_hblnk || r1_vblnk) begin
      w_rgb = 12'h000;
    end else if (r1_in_map) begin
      case (w_tile)
        PLAYER1: w_rgb = (w_coll && w_blink) ? r1_rgb : PLAYER1_COLOR;
        PLAYER2: w_rgb = PLAYER2_COLOR;
        EMPTY:   w_rgb = r1_on_grid ? GRID_COLOR : r1_rgb;
        default: w_rgb = DEBUG_COLOR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_hcount <= '0;
      o_vcount <= '0;
      o_hsync  <= 1'b0;
      o_vsync  <= 1'b0;
      o_hblnk  <= 1'b0;
      o_vblnk  <= 1'b0;
      o_rgb    <= '0;
    end else begin
      o_hcount <= r1_hcount;
      o_vcount <= r1_vcount;
      o_hsync  <= r1_hsync;
      o_vsync  <= r1_vsync;
      o_hblnk  <= r1_hblnk;
      o_vblnk  <= r1_vblnk;
      o_rgb    <= w_rgb;
    end
  end
endmodule

// File: tb/tb_map_draw.sv
module tb_map_draw;
  import game_pkg::*;

  localparam logic [11:0] BG = 12'hABC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tile         map [MAP_WIDTH][MAP_HEIGHT];
  logic        coll = 1'b0;
  logic [10:0] hc = '0, vc = '0;
  logic        hs = 1'b0, vs = 1'b0, hb = 1'b0, vb = 1'b0;
  logic [11:0] rgb = BG;

  logic [10:0] o0_hc, o0_vc, o1_hc, o1_vc;
  logic        o0_hs, o0_vs, o0_hb, o0_vb, o1_hs, o1_vs, o1_hb, o1_vb;
  logic [11:0] o0_rgb, o1_rgb;

  int errors = 0;
  int checks = 0;

  map_draw #(.TILE_SIZE(16), .X_OFFSET(0), .Y_OFFSET(0), .BLINK_FRAMES(2), .GRID_EN(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_map(map), .i_player1_collision(coll),
    .i_hcount(hc), .i_vcount(vc), .i_hsync(hs), .i_vsync(vs), .i_hblnk(hb), .i_vblnk(vb), .i_rgb(rgb),
    .o_hcount(o0_hc), .o_vcount(o0_vc), .o_hsync(o0_hs), .o_vsync(o0_vs), .o_hblnk(o0_hb),
    .o_vblnk(o0_vb), .o_rgb(o0_rgb));

  map_draw #(.TILE_SIZE(16), .X_OFFSET(32), .Y_OFFSET(0), .BLINK_FRAMES(2), .GRID_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_map(map), .i_player1_collision(coll),
    .i_hcount(hc), .i_vcount(vc), .i_hsync(hs), .i_vsync(vs), .i_hblnk(hb), .i_vblnk(vb), .i_rgb(rgb),
    .o_hcount(o1_hc), .o_vcount(o1_vc), .o_hsync(o1_hs), .o_vsync(o1_vs), .o_hblnk(o1_hb),
    .o_vblnk(o1_vb), .o_rgb(o1_rgb));

  // Drive one pixel and return when its composited result is on the outputs.
  task automatic drive_pix(input logic [10:0] h, input logic [10:0] v, input logic hblank);
    @(negedge clk);
    hc = h; vc = v; hb = hblank; vb = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic vblank_pulse();
    @(negedge clk);
    vb = 1'b1; hb = 1'b1;
    repeat (3) @(negedge clk);
    vb = 1'b0; hb = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    map[10][18] = PLAYER1;
    hc = 11'h5A5; vc = 11'h2A2; hs = 1'b1; vs = 1'b1; hb = 1'b1; vb = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (o0_rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb0: got %h want 000", o0_rgb); end
    checks++;
    if ({o0_hc, o0_vc} !== 22'd0) begin errors++; $display("FAIL reset_cnt0: got %h/%h want 0", o0_hc, o0_vc); end
    checks++;
    if ({o0_hs, o0_vs, o0_hb, o0_vb} !== 4'b0) begin
      errors++; $display("FAIL reset_sync0: got %b want 0000", {o0_hs, o0_vs, o0_hb, o0_vb});
    end
    checks++;
    if ({o1_rgb, o1_hc, o1_vc, o1_hs, o1_vs, o1_hb, o1_vb} !== 38'd0) begin
      errors++; $display("FAIL reset_dut1: got rgb=%h hc=%h want all 0", o1_rgb, o1_hc);
    end
    // Release with vblnk already high: that must not count as a capture edge.
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vb = 1'b0; hb = 1'b0; hs = 1'b0; vs = 1'b0;
    drive_pix(11'd168, 11'd292, 1'b0);
    checks++;
    if (o0_rgb !== BG) begin errors++; $display("FAIL reset_no_snap: got %h want %h", o0_rgb, BG); end
    drive_pix(11'd160, 11'd288, 1'b0);
    checks++;
    if (o0_rgb !== 12'h333) begin errors++; $display("FAIL reset_grid: got %h want 333", o0_rgb); end
  endtask

  task automatic test_snapshot();
    map[10][18] = PLAYER1;
    map[11][18] = PLAYER2;
    map[12][18] = tile'(2'd3);
    coll = 1'b0;
    vblank_pulse();
    drive_pix(11'd168, 11'd292, 1'b0);
    checks++;
    if (o0_rgb !== 12'hF00) begin errors++; $display("FAIL snap_p1: got %h want F00", o0_rgb); end
    checks++;
    if (o0_hc !== 11'd168 || o0_vc !== 11'd292) begin
      errors++; $display("FAIL snap_cnt: got %0d/%0d want 168/292", o0_hc, o0_vc);
    end
    checks++;
    if (o1_rgb !== BG) begin errors++; $display("FAIL snap_off_empty: got %h want %h", o1_rgb, BG); end
    drive_pix(11'd184, 11'd292, 1'b0);
    checks++;
    if (o0_rgb !== 12'h00F) begin errors++; $display("FAIL snap_p2: got %h want 00F", o0_rgb); end
    drive_pix(11'd200, 11'd292, 1'b0);
    checks++;
    if (o0_rgb !== 12'hF0F) begin errors++; $display("FAIL snap_debug: got %h want F0F", o0_rgb); end
    checks++;
    if (o1_rgb !== 12'hF00) begin errors++; $display("FAIL snap_off_p1: got %h want F00", o1_rgb); end
  endtask

  task automatic test_tear_free();
    map[10][18] = EMPTY;
    drive_pix(11'd168, 11'd292, 1'b0);
    checks++;
    if (o0_rgb !== 12'hF00) begin errors++; $display("FAIL tear_same_frame: got %h want F00", o0_rgb); end
    vblank_pulse();
    drive_pix(11'd168, 11'd292, 1'b0);
    checks++;
    if (o0_rgb !== BG) begin errors++; $display("FAIL tear_next_frame: got %h want %h", o0_rgb, BG); end
  endtask

  task automatic test_blink();
    logic [11:0] exp_on [6];
    exp_on = '{12'hF00, BG, BG, 12'hF00, 12'hF00, BG};
    map[10][18] = PLAYER1;
    coll = 1'b1;
    for (int f = 0; f < 6; f++) begin
      vblank_pulse();
      drive_pix(11'd168, 11'd292, 1'b0);
      checks++;
      if (o0_rgb !== exp_on[f]) begin
        errors++; $display("FAIL blink_frame%0d: got %h want %h", f, o0_rgb, exp_on[f]);
      end
    end
    coll = 1'b0;
    for (int f = 0; f < 2; f++) begin
      vblank_pulse();
      drive_pix(11'd168, 11'd292, 1'b0);
      checks++;
      if (o0_rgb !== 12'hF00) begin errors++; $display("FAIL blink_steady%0d: got %h want F00", f, o0_rgb); end
    end
  endtask

  task automatic test_boundary();
    map[31][6] = PLAYER2;
    vblank_pulse();
    drive_pix(11'd31, 11'd100, 1'b0);
    checks++;
    if (o1_rgb !== BG) begin errors++; $display("FAIL bnd_left_of_off: got %h want %h", o1_rgb, BG); end
    drive_pix(11'd32, 11'd100, 1'b0);
    checks++;
    if (o1_rgb !== 12'h333) begin errors++; $display("FAIL bnd_first_px: got %h want 333", o1_rgb); end
    drive_pix(11'd543, 11'd100, 1'b0);
    checks++;
    if (o1_rgb !== 12'h00F) begin errors++; $display("FAIL bnd_last_px_off: got %h want 00F", o1_rgb); end
    drive_pix(11'd544, 11'd100, 1'b0);
    checks++;
    if (o1_rgb !== BG) begin errors++; $display("FAIL bnd_past_off: got %h want %h", o1_rgb, BG); end
    drive_pix(11'd511, 11'd100, 1'b0);
    checks++;
    if (o0_rgb !== 12'h00F) begin errors++; $display("FAIL bnd_last_px: got %h want 00F", o0_rgb); end
    drive_pix(11'd512, 11'd100, 1'b0);
    checks++;
    if (o0_rgb !== BG) begin errors++; $display("FAIL bnd_past: got %h want %h", o0_rgb, BG); end
    drive_pix(11'd16, 11'd383, 1'b0);
    checks++;
    if (o0_rgb !== 12'h333) begin errors++; $display("FAIL bnd_last_row: got %h want 333", o0_rgb); end
    drive_pix(11'd16, 11'd384, 1'b0);
    checks++;
    if (o0_rgb !== BG) begin errors++; $display("FAIL bnd_past_row: got %h want %h", o0_rgb, BG); end
    drive_pix(11'd168, 11'd292, 1'b1);
    checks++;
    if (o0_rgb !== 12'h000) begin errors++; $display("FAIL bnd_hblank: got %h want 000", o0_rgb); end
  endtask

  task automatic test_alignment();
    logic [25:0] cur, p1, p2;
    cur = '0; p1 = '0; p2 = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if ({o0_hc, o0_vc, o0_hs, o0_vs, o0_hb, o0_vb} !== p1) begin
          errors++; $display("FAIL align0 cyc%0d: got %h want %h", i,
                             {o0_hc, o0_vc, o0_hs, o0_vs, o0_hb, o0_vb}, p1);
        end
        checks++;
        if ({o1_hc, o1_vc, o1_hs, o1_vs, o1_hb, o1_vb} !== p1) begin
          errors++; $display("FAIL align1 cyc%0d: got %h want %h", i,
                             {o1_hc, o1_vc, o1_hs, o1_vs, o1_hb, o1_vb}, p1);
        end
      end
      // p1 holds the vector driven two negedges before the upcoming sample.
      p1 = p2;
      cur = 26'($urandom);
      {hc, vc, hs, vs, hb, vb} = cur;
      p2 = cur;
    end
  endtask

  initial begin
    for (int x = 0; x < MAP_WIDTH; x++)
      for (int y = 0; y < MAP_HEIGHT; y++)
        map[x][y] = EMPTY;
    test_reset();
    test_snapshot();
    test_tear_free();
    test_blink();
    test_boundary();
    test_alignment();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
